// File: rtl/nrisc_fwd_pipe_if.sv
// Bundle of the EXEC/ID-side and write-back signals of the forwarding pipe.
// master is the core side; slave is the forwarding pipe itself.
interface nrisc_fwd_pipe_if #(
  parameter int TAM = 16,
  parameter int RB  = 4
);
  logic           ex_valid;
  logic           ex_write;
  logic           ex_load;
  logic [RB-1:0]  ex_rd;
  logic [TAM-1:0] ex_data;
  logic           flush;
  logic [TAM-1:0] mem_data;
  logic [RB-1:0]  rf1;
  logic [RB-1:0]  rf2;
  logic [TAM-1:0] reg_a;
  logic [TAM-1:0] reg_b;
  logic [TAM-1:0] op_a;
  logic [TAM-1:0] op_b;
  logic           hz_stall;
  logic           wb_write;
  logic [RB-1:0]  wb_rd;
  logic [TAM-1:0] wb_data;
  logic           cnt_clr;
  logic [15:0]    cnt_stall;

  modport master (
    output ex_valid, ex_write, ex_load, ex_rd, ex_data, flush, mem_data,
           rf1, rf2, reg_a, reg_b, cnt_clr,
    input  op_a, op_b, hz_stall, wb_write, wb_rd, wb_data, cnt_stall
  );

  modport slave (
    input  ex_valid, ex_write, ex_load, ex_rd, ex_data, flush, mem_data,
           rf1, rf2, reg_a, reg_b, cnt_clr,
    output op_a, op_b, hz_stall, wb_write, wb_rd, wb_data, cnt_stall
  );
endinterface

// File: rtl/nrisc_fwd_pipe.sv
// Post-EXEC destination tracking with operand forwarding, load-use hazard
// detection and a saturating stall counter. Last stage drives write-back.
module nrisc_fwd_pipe #(
  parameter int TAM   = 16,
  parameter int RB    = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  nrisc_fwd_pipe_if.slave  bus
);

  logic           s_valid [DEPTH];
  logic           s_load  [DEPTH];
  logic [RB-1:0]  s_rd    [DEPTH];
  logic [TAM-1:0] s_data  [DEPTH];

  logic           hz;
  logic [15:0]    cnt;
  logic [TAM-1:0] op_a;
  logic [TAM-1:0] op_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        s_valid[k] <= 1'b0;
        s_load[k]  <= 1'b0;
        s_rd[k]    <= '0;
        s_data[k]  <= '0;
      end
    end else begin
      s_valid[0] <= bus.ex_valid & bus.ex_write & ~bus.flush;
      s_load[0]  <= bus.ex_load;
      s_rd[0]    <= bus.ex_rd;
      s_data[0]  <= bus.ex_data;
      for (int k = 1; k < DEPTH; k++) begin
        s_valid[k] <= s_valid[k-1];
        s_load[k]  <= s_load[k-1];
        s_rd[k]    <= s_rd[k-1];
        s_data[k]  <= s_data[k-1];
      end
      // Load data arrives while the load sits in S0; from S1 on it is ordinary data.
      if (s_load[0]) begin
        s_data[1] <= bus.mem_data;
        s_load[1] <= 1'b0;
      end
    end
  end

  // Walk oldest to youngest so the youngest match overwrites; a pending load
  // falls back to the register file rather than exposing an older value.
  always_comb begin
    op_a = bus.reg_a;
    op_b = bus.reg_b;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (s_valid[k] && (s_rd[k] == bus.rf1))
        op_a = s_load[k] ? bus.reg_a : s_data[k];
      if (s_valid[k] && (s_rd[k] == bus.rf2))
        op_b = s_load[k] ? bus.reg_b : s_data[k];
    end
  end

  assign hz = s_valid[0] & s_load[0] &
              ((s_rd[0] == bus.rf1) | (s_rd[0] == bus.rf2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (bus.cnt_clr)
      cnt <= '0;
    else if (hz && (cnt != 16'hFFFF))
      cnt <= cnt + 16'd1;
  end

  assign bus.op_a      = op_a;
  assign bus.op_b      = op_b;
  assign bus.hz_stall  = hz;
  assign bus.wb_write  = s_valid[DEPTH-1];
  assign bus.wb_rd     = s_rd[DEPTH-1];
  assign bus.wb_data   = s_data[DEPTH-1];
  assign bus.cnt_stall = cnt;

endmodule

// File: tb/tb_nrisc_fwd_pipe.sv
// Directed bench for nrisc_fwd_pipe: per-cycle vector table on a DEPTH=2
// instance plus hand sequences for priority, saturation and reset.
module tb_nrisc_fwd_pipe;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  nrisc_fwd_pipe_if #(.TAM(16), .RB(4)) b2 ();
  nrisc_fwd_pipe_if #(.TAM(16), .RB(4)) b4 ();

  nrisc_fwd_pipe #(.TAM(16), .RB(4), .DEPTH(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
  nrisc_fwd_pipe #(.TAM(16), .RB(4), .DEPTH(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v, w, ld;
    logic [3:0]  rd;
    logic [15:0] d;
    logic        fl;
    logic [15:0] md;
    logic [3:0]  r1, r2;
    logic [15:0] ra, rb;
    logic        clr;
    logic        opchk;
    logic [15:0] ea, eb;
    logic        ehz, ewb;
    logic [3:0]  erd;
    logic [15:0] ewd, ecnt;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv2(input logic v, w, ld, input logic [3:0] rd, input logic [15:0] d,
                      input logic fl, input logic [15:0] md, input logic [3:0] r1, r2,
                      input logic [15:0] ra, rb, input logic clr);
    b2.ex_valid = v;  b2.ex_write = w;  b2.ex_load = ld;
    b2.ex_rd = rd;    b2.ex_data = d;   b2.flush = fl;
    b2.mem_data = md; b2.rf1 = r1;      b2.rf2 = r2;
    b2.reg_a = ra;    b2.reg_b = rb;    b2.cnt_clr = clr;
  endtask

  task automatic idle4();
    b4.ex_valid = 0; b4.ex_write = 0; b4.ex_load = 0; b4.ex_rd = 0;
    b4.ex_data = 0;  b4.flush = 0;    b4.mem_data = 0; b4.rf1 = 0;
    b4.rf2 = 0;      b4.reg_a = 0;    b4.reg_b = 0;    b4.cnt_clr = 0;
  endtask

  function automatic vec_t mk(logic v, w, ld, logic [3:0] rd, logic [15:0] d, logic fl,
                              logic [15:0] md, logic [3:0] r1, r2, logic [15:0] ra, rb,
                              logic clr, logic opchk, logic [15:0] ea, eb, logic ehz, ewb,
                              logic [3:0] erd, logic [15:0] ewd, ecnt);
    vec_t t;
    t.v = v; t.w = w; t.ld = ld; t.rd = rd; t.d = d; t.fl = fl; t.md = md;
    t.r1 = r1; t.r2 = r2; t.ra = ra; t.rb = rb; t.clr = clr; t.opchk = opchk;
    t.ea = ea; t.eb = eb; t.ehz = ehz; t.ewb = ewb; t.erd = erd; t.ewd = ewd; t.ecnt = ecnt;
    return t;
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    //               v  w  ld rd  d        fl md       r1 r2 ra       rb       clr chk ea       eb       hz wb rd  wd       cnt
    vecs[0]  = mk(1, 1, 0, 3, 16'h0011, 0, 16'h0000, 0, 0, 16'h0100, 16'h0200, 0, 1, 16'h0100, 16'h0200, 0, 0, 0, 16'h0000, 0);
    vecs[1]  = mk(1, 1, 0, 3, 16'h0022, 0, 16'h0000, 1, 2, 16'h0101, 16'h0202, 0, 1, 16'h0101, 16'h0202, 0, 0, 0, 16'h0000, 0);
    vecs[2]  = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 3, 3, 16'h0000, 16'h0555, 0, 1, 16'h0022, 16'h0022, 0, 1, 3, 16'h0011, 0);
    vecs[3]  = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 3, 4, 16'h0333, 16'h0444, 0, 1, 16'h0022, 16'h0444, 0, 1, 3, 16'h0022, 0);
    vecs[4]  = mk(1, 1, 0, 7, 16'h1234, 1, 16'h0000, 0, 0, 16'h0001, 16'h0002, 0, 1, 16'h0001, 16'h0002, 0, 0, 0, 16'h0000, 0);
    vecs[5]  = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 7, 7, 16'h00AA, 16'h00BB, 0, 1, 16'h00AA, 16'h00BB, 0, 0, 0, 16'h0000, 0);
    vecs[6]  = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 7, 0, 16'h00AA, 16'h0010, 0, 1, 16'h00AA, 16'h0010, 0, 0, 7, 16'h1234, 0);
    vecs[7]  = mk(1, 1, 1, 5, 16'h9999, 0, 16'h0000, 0, 0, 16'h0001, 16'h0002, 0, 1, 16'h0001, 16'h0002, 0, 0, 0, 16'h0000, 0);
    vecs[8]  = mk(0, 0, 0, 0, 16'h0000, 0, 16'hBEEF, 1, 5, 16'h0011, 16'h0055, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0);
    vecs[9]  = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 5, 16'h0011, 16'h0055, 0, 1, 16'h0011, 16'hBEEF, 0, 1, 5, 16'hBEEF, 1);
    vecs[10] = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0003, 16'h0004, 1, 1, 16'h0003, 16'h0004, 0, 0, 0, 16'h0000, 1);
    vecs[11] = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0005, 16'h0006, 0, 1, 16'h0005, 16'h0006, 0, 0, 0, 16'h0000, 0);
    vecs[12] = mk(1, 1, 0, 0, 16'h00F0, 0, 16'h0000, 1, 1, 16'h0007, 16'h0008, 0, 1, 16'h0007, 16'h0008, 0, 0, 0, 16'h0000, 0);
    vecs[13] = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0009, 16'h000A, 0, 1, 16'h00F0, 16'h00F0, 0, 0, 0, 16'h0000, 0);
    vecs[14] = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h000B, 16'h000C, 0, 1, 16'h00F0, 16'h000C, 0, 1, 0, 16'h00F0, 0);

    // Reset state
    rst = 1'b0;
    drv2(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h5A5A, 16'hA5A5, 0);
    idle4();
    b4.reg_a = 16'h1357;
    repeat (2) @(negedge clk);
    chk("rst_op_a", b2.op_a, 16'h5A5A);
    chk("rst_op_b", b2.op_b, 16'hA5A5);
    chk("rst_hz", b2.hz_stall, 0);
    chk("rst_wb_write", b2.wb_write, 0);
    chk("rst_wb_rd", b2.wb_rd, 0);
    chk("rst_wb_data", b2.wb_data, 0);
    chk("rst_cnt", b2.cnt_stall, 0);
    chk("rst4_op_a", b4.op_a, 16'h1357);
    chk("rst4_wb_write", b4.wb_write, 0);
    @(posedge clk); #1 rst = 1'b1;
    drv2(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    // Vector table on DEPTH=2
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      drv2(vecs[i].v, vecs[i].w, vecs[i].ld, vecs[i].rd, vecs[i].d, vecs[i].fl, vecs[i].md,
           vecs[i].r1, vecs[i].r2, vecs[i].ra, vecs[i].rb, vecs[i].clr);
      @(negedge clk);
      if (vecs[i].opchk) begin
        chk($sformatf("v%0d_op_a", i), b2.op_a, vecs[i].ea);
        chk($sformatf("v%0d_op_b", i), b2.op_b, vecs[i].eb);
      end
      chk($sformatf("v%0d_hz", i), b2.hz_stall, vecs[i].ehz);
      chk($sformatf("v%0d_wb_write", i), b2.wb_write, vecs[i].ewb);
      chk($sformatf("v%0d_wb_rd", i), b2.wb_rd, vecs[i].erd);
      chk($sformatf("v%0d_wb_data", i), b2.wb_data, vecs[i].ewd);
      chk($sformatf("v%0d_cnt", i), b2.cnt_stall, vecs[i].ecnt);
    end
    @(posedge clk); #1;
    drv2(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Priority on DEPTH=4: three writes to R2, youngest wins, in-order write-back
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      b4.ex_valid = 1; b4.ex_write = 1; b4.ex_rd = 4'd2; b4.ex_data = 16'(i);
    end
    @(posedge clk); #1;
    b4.ex_valid = 0; b4.ex_write = 0; b4.ex_rd = 0; b4.ex_data = 0;
    b4.rf1 = 4'd2; b4.reg_a = 16'hFFFF;
    @(negedge clk);
    chk("d4_op_a", b4.op_a, 16'h0003);
    chk("d4_wb_early", b4.wb_write, 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("d4_wb%0d_write", i), b4.wb_write, 1);
      chk($sformatf("d4_wb%0d_rd", i), b4.wb_rd, 2);
      chk($sformatf("d4_wb%0d_data", i), b4.wb_data, 16'(i));
      if (i == 1) chk("d4_op_a_wb1", b4.op_a, 16'h0003);
    end
    @(negedge clk);
    chk("d4_wb_done", b4.wb_write, 0);
    chk("d4_op_a_none", b4.op_a, 16'hFFFF);
    idle4();

    // Saturation: a load to R5 every cycle with rf1 = 5 keeps hz_stall high
    @(posedge clk); #1;
    drv2(1, 1, 1, 5, 0, 0, 0, 5, 0, 0, 0, 0);
    @(negedge clk);
    chk("sat_cnt_start", b2.cnt_stall, 0);
    @(negedge clk);
    chk("sat_hz", b2.hz_stall, 1);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("sat_cnt_fffe", b2.cnt_stall, 16'hFFFE);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("sat_cnt_ffff", b2.cnt_stall, 16'hFFFF);
    b2.cnt_clr = 1;
    @(negedge clk);
    chk("sat_clr_hz", b2.hz_stall, 1);
    chk("sat_clr_cnt", b2.cnt_stall, 0);
    @(posedge clk); #1;
    drv2(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);

    // Reset mid-flight with two writes pending
    @(posedge clk); #1;
    drv2(1, 1, 0, 9, 16'h0101, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drv2(1, 1, 0, 9, 16'h0202, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drv2(0, 0, 0, 0, 0, 0, 0, 9, 9, 16'h7777, 16'h8888, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_wb_write", b2.wb_write, 0);
    chk("mrst_wb_rd", b2.wb_rd, 0);
    chk("mrst_wb_data", b2.wb_data, 0);
    chk("mrst_op_a", b2.op_a, 16'h7777);
    chk("mrst_hz", b2.hz_stall, 0);
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_wb_write", i), b2.wb_write, 0);
      chk($sformatf("post_rst%0d_op_a", i), b2.op_a, 16'h7777);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
